// File: rtl/ti_pkg.sv
// Shared types, payload mode encodings and parameter checks for the payload gate.
package ti_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StFired,
        StDone
    } state_e;

    localparam int unsigned MODE_FORCE0 = 0;
    localparam int unsigned MODE_INVERT = 1;
    localparam int unsigned MODE_FORCE1 = 2;

    // The threshold has to be reachable by the counter without wrapping.
    function automatic bit thresh_ok(input int unsigned thresh, input int unsigned cnt_w);
        longint unsigned max_cnt;
        max_cnt = (64'd1 << cnt_w) - 64'd1;
        return (thresh >= 1) && (64'(thresh) <= max_cnt);
    endfunction

endpackage

// File: rtl/ti_trig_cnt.sv
// Trigger event counter and fired-duration counter with the IDLE/COUNT/FIRED/DONE sequence.
module ti_trig_cnt
    import ti_pkg::*;
#(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned THRESH = 5,
    parameter int unsigned DUR    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_evt,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             fired,
    output logic             active
);

    localparam int unsigned      DUR_W    = (DUR == 0) ? 1 : $clog2(DUR + 1);
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'((DUR == 0) ? 0 : DUR - 1);
    localparam logic [CNT_W:0]   THRESH_X = (CNT_W + 1)'(THRESH);

    state_e           state;
    logic [DUR_W-1:0] dur;
    logic [CNT_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);

    // The threshold-reaching event gates its own cycle; DONE ignores events and clr wins.
    always_comb begin
        active = 1'b0;
        if (!clr) begin
            active = (state == StFired) ||
                     (trig_evt && (state != StDone) && (cnt_inc >= THRESH_X));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            cnt   <= '0;
            dur   <= '0;
            fired <= 1'b0;
        end else if (clr) begin
            state <= StIdle;
            cnt   <= '0;
            dur   <= '0;
            fired <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (trig_evt) begin
                        cnt <= CNT_W'(1);
                        if (THRESH == 1) begin
                            state <= StFired;
                            dur   <= '0;
                            fired <= 1'b1;
                        end else begin
                            state <= StCount;
                        end
                    end
                end
                StCount: begin
                    if (trig_evt) begin
                        cnt <= cnt_inc[CNT_W-1:0];
                        if (cnt_inc == THRESH_X) begin
                            state <= StFired;
                            dur   <= '0;
                            fired <= 1'b1;
                        end
                    end
                end
                StFired: begin
                    if (DUR != 0) begin
                        if (dur == DUR_LAST) begin
                            state <= StDone;
                            cnt   <= '0;
                            dur   <= '0;
                            fired <= 1'b0;
                        end else begin
                            dur <= dur + DUR_W'(1);
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    fired <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ti_payload_gate.sv
// Counts trigger events and, once the threshold is reached, applies a masked payload
// to the registered copy of the host outputs.
module ti_payload_gate
    import ti_pkg::*;
#(
    parameter int unsigned N_OUT  = 39,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned THRESH = 5,
    parameter int unsigned MODE   = 0,
    parameter int unsigned DUR    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_OUT-1:0] fn_out,
    input  logic             trig_evt,
    input  logic [N_OUT-1:0] pay_mask,
    input  logic             clr,
    output logic [N_OUT-1:0] y,
    output logic             fired,
    output logic [CNT_W-1:0] cnt
);

    if (!thresh_ok(THRESH, CNT_W)) begin : g_thresh_check
        $error("THRESH must lie in 1 .. 2**CNT_W-1");
    end

    logic             active;
    logic [N_OUT-1:0] payload;

    ti_trig_cnt #(
        .CNT_W  (CNT_W),
        .THRESH (THRESH),
        .DUR    (DUR)
    ) u_trig_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_evt (trig_evt),
        .clr      (clr),
        .cnt      (cnt),
        .fired    (fired),
        .active   (active)
    );

    always_comb begin
        payload = fn_out;
        if (MODE == MODE_FORCE0) begin
            payload = fn_out & ~pay_mask;
        end else if (MODE == MODE_INVERT) begin
            payload = fn_out ^ pay_mask;
        end else if (MODE == MODE_FORCE1) begin
            payload = fn_out | pay_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else begin
            y <= active ? payload : fn_out;
        end
    end

endmodule

// File: tb/tb_ti_payload_gate.sv
// Scoreboard bench for ti_payload_gate across four parameter sets sharing one stimulus bus.
module tb_ti_payload_gate;

    localparam int unsigned NO = 39;
    localparam logic [NO-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NO-1:0] fn_out = '0;
    logic [NO-1:0] pay_mask = '0;
    logic          trig_evt = 1'b0;
    logic          clr = 1'b0;

    logic [3:0][NO-1:0] y_s;
    logic [3:0]         f_s;
    logic [3:0][7:0]    c_s;

    int n_total = 0;
    int n_pass = 0;

    typedef struct {
        int            idx;
        logic [NO-1:0] y;
        logic          fired;
        logic [7:0]    cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // 0: THRESH=5 force-0 persistent; 1: THRESH=2 invert; 2: THRESH=2 force-1 DUR=3; 3: THRESH=1
    ti_payload_gate #(.N_OUT(NO), .CNT_W(8), .THRESH(5), .MODE(0), .DUR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .fn_out(fn_out), .trig_evt(trig_evt), .pay_mask(pay_mask),
        .clr(clr), .y(y_s[0]), .fired(f_s[0]), .cnt(c_s[0])
    );
    ti_payload_gate #(.N_OUT(NO), .CNT_W(8), .THRESH(2), .MODE(1), .DUR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .fn_out(fn_out), .trig_evt(trig_evt), .pay_mask(pay_mask),
        .clr(clr), .y(y_s[1]), .fired(f_s[1]), .cnt(c_s[1])
    );
    ti_payload_gate #(.N_OUT(NO), .CNT_W(8), .THRESH(2), .MODE(2), .DUR(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .fn_out(fn_out), .trig_evt(trig_evt), .pay_mask(pay_mask),
        .clr(clr), .y(y_s[2]), .fired(f_s[2]), .cnt(c_s[2])
    );
    ti_payload_gate #(.N_OUT(NO), .CNT_W(8), .THRESH(1), .MODE(0), .DUR(0)) dut_d (
        .clk(clk), .rst_n(rst_n), .fn_out(fn_out), .trig_evt(trig_evt), .pay_mask(pay_mask),
        .clr(clr), .y(y_s[3]), .fired(f_s[3]), .cnt(c_s[3])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the outputs expected after the edge, then check them.
    task automatic cyc(input string tag, input int idx, input logic t, input logic c,
                       input logic [NO-1:0] ey, input logic ef, input logic [7:0] ec);
        exp_t e;
        exp_t got;
        trig_evt = t;
        clr      = c;
        e.idx    = idx;
        e.y      = ey;
        e.fired  = ef;
        e.cnt    = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        trig_evt = 1'b0;
        clr      = 1'b0;
        got = sb.pop_front();
        check_eq({tag, ".y"}, 64'(y_s[got.idx]), 64'(got.y));
        check_eq({tag, ".fired"}, 64'(f_s[got.idx]), 64'(got.fired));
        check_eq({tag, ".cnt"}, 64'(c_s[got.idx]), 64'(got.cnt));
    endtask

    // Mid-cycle reset pulse, released away from the clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rst%0d.y", i), 64'(y_s[i]), 64'd0);
            check_eq($sformatf("rst%0d.fired", i), 64'(f_s[i]), 64'd0);
            check_eq($sformatf("rst%0d.cnt", i), 64'(c_s[i]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Five single-cycle events: y gated from the fifth, fired the cycle after.
        fn_out   = ONES;
        pay_mask = ONES;
        for (int k = 1; k <= 4; k++) begin
            cyc($sformatf("a_ev%0d", k), 0, 1'b1, 1'b0, ONES, 1'b0, 8'(k));
            cyc($sformatf("a_gap%0d", k), 0, 1'b0, 1'b0, ONES, 1'b0, 8'(k));
        end
        cyc("a_ev5", 0, 1'b1, 1'b0, '0, 1'b1, 8'd5);
        cyc("a_hold", 0, 1'b0, 1'b0, '0, 1'b1, 8'd5);
        cyc("a_sat", 0, 1'b1, 1'b0, '0, 1'b1, 8'd5);
        cyc("a_clr", 0, 1'b0, 1'b1, ONES, 1'b0, 8'd0);
        cyc("a_idle", 0, 1'b0, 1'b0, ONES, 1'b0, 8'd0);

        // clr beats a simultaneous fifth event.
        for (int k = 1; k <= 4; k++) begin
            cyc($sformatf("c4_ev%0d", k), 0, 1'b1, 1'b0, ONES, 1'b0, 8'(k));
        end
        cyc("c4_clrtrig", 0, 1'b1, 1'b1, ONES, 1'b0, 8'd0);
        cyc("c4_after", 0, 1'b1, 1'b0, ONES, 1'b0, 8'd1);

        // Asynchronous reset in the middle of FIRED discards the history.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            cyc($sformatf("r_ev%0d", k), 0, 1'b1, 1'b0, ONES, 1'b0, 8'(k));
        end
        cyc("r_ev5", 0, 1'b1, 1'b0, '0, 1'b1, 8'd5);
        rst_n = 1'b0;
        #1;
        check_eq("r_async.y", 64'(y_s[0]), 64'd0);
        check_eq("r_async.fired", 64'(f_s[0]), 64'd0);
        check_eq("r_async.cnt", 64'(c_s[0]), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 4; k++) begin
            cyc($sformatf("r_post%0d", k), 0, 1'b1, 1'b0, ONES, 1'b0, 8'(k));
        end

        // Invert mode on a single masked bit.
        do_reset();
        fn_out   = NO'(3);
        pay_mask = NO'(1);
        cyc("b_ev1", 1, 1'b1, 1'b0, NO'(3), 1'b0, 8'd1);
        cyc("b_ev2", 1, 1'b1, 1'b0, NO'(2), 1'b1, 8'd2);
        cyc("b_hold", 1, 1'b0, 1'b0, NO'(2), 1'b1, 8'd2);
        pay_mask = '0;
        cyc("b_nomask", 1, 1'b0, 1'b0, NO'(3), 1'b1, 8'd2);
        fn_out   = NO'(5);
        pay_mask = NO'(4);
        cyc("b_inv", 1, 1'b0, 1'b0, NO'(1), 1'b1, 8'd2);

        // Three-cycle fired window, DONE ignores events, then a second firing.
        do_reset();
        fn_out   = NO'('h0f0);
        pay_mask = NO'('hf00);
        cyc("d_ev1", 2, 1'b1, 1'b0, NO'('h0f0), 1'b0, 8'd1);
        cyc("d_ev2", 2, 1'b1, 1'b0, NO'('hff0), 1'b1, 8'd2);
        cyc("d_f2", 2, 1'b0, 1'b0, NO'('hff0), 1'b1, 8'd2);
        cyc("d_f3", 2, 1'b0, 1'b0, NO'('hff0), 1'b1, 8'd2);
        cyc("d_done", 2, 1'b0, 1'b0, NO'('hff0), 1'b0, 8'd0);
        cyc("d_ign", 2, 1'b1, 1'b0, NO'('h0f0), 1'b0, 8'd0);
        cyc("d_re1", 2, 1'b1, 1'b0, NO'('h0f0), 1'b0, 8'd1);
        cyc("d_re2", 2, 1'b1, 1'b0, NO'('hff0), 1'b1, 8'd2);

        // THRESH=1 fires on the very first event.
        do_reset();
        fn_out   = ONES;
        pay_mask = ONES;
        cyc("t1_idle", 3, 1'b0, 1'b0, ONES, 1'b0, 8'd0);
        cyc("t1_ev", 3, 1'b1, 1'b0, '0, 1'b1, 8'd1);
        cyc("t1_hold", 3, 1'b0, 1'b0, '0, 1'b1, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ti_payload_gate.md
TI_PAYLOAD_GATE -- requirements
Module: ti_payload_gate

Interface
REQ-001 SHALL have parameter N_OUT, default 39: width of the functional output vector.
REQ-002 SHALL have parameter CNT_W, default 8: trigger counter width; a static check fails unless 1 <= THRESH <= 2^CNT_W-1.
REQ-003 SHALL have parameter THRESH, default 5: number of trigger events that causes firing.
REQ-004 SHALL have parameter MODE, default 0: payload action, 0=force-0, 1=invert, 2=force-1.
REQ-005 SHALL have parameter DUR, default 0: fired duration in cycles; 0=persistent until clear or reset.
REQ-006 SHALL have one clock and asynchronous active-low reset: clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port fn_out  in  N_OUT  golden outputs from the host FSM.
REQ-009 SHALL have port trig_evt  in  1  one trigger event per cycle while high.
REQ-010 SHALL have port pay_mask  in  N_OUT  bits subject to the payload.
REQ-011 SHALL have port clr  in  1  synchronous clear of counter and state.
REQ-012 SHALL have port y  out  N_OUT  registered gated outputs.
REQ-013 SHALL have port fired  out  1  high while in FIRED.
REQ-014 SHALL have port cnt  out  CNT_W  current event count.

Function
REQ-015 SHALL implement states IDLE, COUNT, FIRED, DONE.
REQ-016 IDLE: trig_evt -> cnt=1, go COUNT; or, if THRESH=1, go FIRED.
REQ-017 COUNT: trig_evt -> cnt+1; go FIRED when cnt+1 == THRESH.
REQ-018 FIRED, DUR=0: remain until clr or reset.
REQ-019 FIRED, DUR>0: remain exactly DUR cycles, then go DONE.
REQ-020 DONE: cnt=0, go IDLE next cycle; trig_evt in DONE is ignored.
REQ-021 cnt SHALL saturate at THRESH and never wrap; events in FIRED do not change cnt.
REQ-022 active SHALL be (state==FIRED) or (trig_evt and cnt+1 >= THRESH), so the THRESH-th event cycle is already affected.
REQ-023 y SHALL register next = active ? payload(fn_out) : fn_out; latency 1 cycle.
REQ-024 payload SHALL alter only bits with pay_mask=1: force-0 / invert / force-1 per MODE.
REQ-025 clr SHALL take priority over trig_evt in the same cycle: next state IDLE, cnt 0, and that cycle's y is ungated.
REQ-026 fired SHALL be registered state decode; it asserts the cycle after the THRESH-th event edge.
REQ-027 the duration counter SHALL be clog2(DUR+1) bits wide and clear on every entry to FIRED.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, cnt 0, duration counter 0, y all-0, fired 0.
REQ-029 reset mid-FIRED SHALL discard all history; counting restarts from 0 after release.
REQ-030 reset release SHALL be synchronised externally; the block takes no action on the release edge.

Structure
REQ-031 state enum, MODE encodings and the THRESH/CNT_W check SHALL live in shared package ti_pkg.
REQ-032 trigger counter plus duration counter SHALL form sub-module ti_trig_cnt; payload and y register stay in the top.

Verification
REQ-033 THRESH=5, MODE=0, DUR=0, fn_out=all-1, pay_mask=all-1, 5 single-cycle events -> y all-1 after events 1-4, all-0 from event 5 on, fired=1 from next cycle.
REQ-034 MODE=1, pay_mask=0x1, fn_out=0x3, fired -> y=0x2; pay_mask=0 -> y=fn_out.
REQ-035 DUR=3, THRESH=2, 2 events -> fired high exactly 3 cycles, then DONE, then IDLE with cnt=0; next 2 events re-fire.
REQ-036 cnt=4 (THRESH=5), clr and trig_evt in the same cycle -> cnt=0, state IDLE, y ungated.
REQ-037 rst_n pulsed low mid-FIRED between clock edges -> y=0, fired=0, cnt=0 immediately; 4 events after release do not fire.
REQ-038 THRESH=1, one event -> y gated in that event's output cycle, fired next cycle.
